// File: rtl/calc_btn_cond.sv
// Button conditioning for the calculator: five synchronised and debounced channels.
// Also produces execute/clear strobes and holds the op-select snapshot latched at execute.
module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnc_raw,
  input  logic btnl_raw,
  input  logic btnr_raw,
  input  logic btnu_raw,
  input  logic btnd_raw,
  output logic btnc,
  output logic btnl,
  output logic btnr,
  output logic op_btnc,
  output logic op_btnl,
  output logic op_btnr,
  output logic exec_pulse,
  output logic clr_pulse
);

  localparam int unsigned NCH  = 5;
  localparam int unsigned CH_U = 3;
  localparam int unsigned CH_D = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: {d, u, r, l, c}
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q, s2_q, db_q, db_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             rise_u, rise_d;
  logic             exec_q, exec_d, clr_q, clr_d;
  logic [2:0]       op_q, op_d;

  assign raw = {btnd_raw, btnu_raw, btnr_raw, btnl_raw, btnc_raw};

  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) db_d[i]  = s2_q[i];
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Clear wins over a coincident execute; the op latch samples pre-edge levels.
  always_comb begin
    rise_u = db_d[CH_U] & ~db_q[CH_U];
    rise_d = db_d[CH_D] & ~db_q[CH_D];
    clr_d  = rise_u;
    exec_d = rise_d & ~rise_u;
    op_d   = exec_d ? db_q[2:0] : op_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      exec_q <= 1'b0;
      clr_q  <= 1'b0;
      op_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      exec_q <= exec_d;
      clr_q  <= clr_d;
      op_q   <= op_d;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btnc       = db_q[0];
  assign btnl       = db_q[1];
  assign btnr       = db_q[2];
  assign op_btnc    = op_q[0];
  assign op_btnl    = op_q[1];
  assign op_btnr    = op_q[2];
  assign exec_pulse = exec_q;
  assign clr_pulse  = clr_q;

endmodule

// File: tb/tb_calc_btn_cond.sv
// Bench for calc_btn_cond: per-cycle reference model via scoreboard queue,
// segment table with expected strobe counts/timing, plus corner-case sequences.
module tb_calc_btn_cond;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] raw;   // {d, u, r, l, c}
  logic btnc, btnl, btnr, op_btnc, op_btnl, op_btnr, exec_pulse, clr_pulse;

  logic       rst1_n;
  logic [4:0] raw1;
  logic btnc1, btnl1, btnr1, op_btnc1, op_btnl1, op_btnr1, exec1, clr1;

  calc_btn_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .btnc_raw(raw[0]), .btnl_raw(raw[1]), .btnr_raw(raw[2]),
    .btnu_raw(raw[3]), .btnd_raw(raw[4]),
    .btnc(btnc), .btnl(btnl), .btnr(btnr),
    .op_btnc(op_btnc), .op_btnl(op_btnl), .op_btnr(op_btnr),
    .exec_pulse(exec_pulse), .clr_pulse(clr_pulse)
  );

  calc_btn_cond #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .btnc_raw(raw1[0]), .btnl_raw(raw1[1]), .btnr_raw(raw1[2]),
    .btnu_raw(raw1[3]), .btnd_raw(raw1[4]),
    .btnc(btnc1), .btnl(btnl1), .btnr(btnr1),
    .op_btnc(op_btnc1), .op_btnl(op_btnl1), .op_btnr(op_btnr1),
    .exec_pulse(exec1), .clr_pulse(clr1)
  );

  typedef struct {
    logic [4:0] raw;
    int         hold;
    int         n_exec;
    int         n_clr;
    int         pulse_at;
    logic [2:0] exp_op;   // {op_btnc, op_btnl, op_btnr}
  } seg_t;

  seg_t       segs [9];
  logic [7:0] exp_q [$];
  int vectors = 0, miscompares = 0;
  int exec_cnt, clr_cnt, pulse_at, idx;

  // Reference model state
  logic [4:0] m_s1, m_s2, m_db;
  int         m_cnt [5];
  logic       m_exec, m_clr;
  logic [2:0] m_op;   // index 0=c, 1=l, 2=r

  function automatic logic [7:0] dut_vec();
    return {op_btnc, op_btnl, op_btnr, btnc, btnl, btnr, exec_pulse, clr_pulse};
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s (t=%0t): got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic model_edge(input logic r, input logic [4:0] v);
    logic [4:0] nd;
    logic ru, rd;
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_exec = 1'b0; m_clr = 1'b0; m_op = '0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else begin
      nd = m_db;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] == m_db[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == N - 1) begin nd[i] = m_s2[i]; m_cnt[i] = 0; end
        else m_cnt[i] = m_cnt[i] + 1;
      end
      ru = nd[3] & ~m_db[3];
      rd = nd[4] & ~m_db[4];
      m_clr  = ru;
      m_exec = rd & ~ru;
      if (m_exec) m_op = m_db[2:0];
      m_db = nd;
      m_s2 = m_s1;
      m_s1 = v;
    end
  endtask

  task automatic step(input logic r, input logic [4:0] v);
    logic [7:0] e;
    rst_n = r;
    raw   = v;
    model_edge(r, v);
    exp_q.push_back({m_op[0], m_op[1], m_op[2], m_db[0], m_db[1], m_db[2], m_exec, m_clr});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("outputs", int'(dut_vec()), int'(e));
    if (exec_pulse) begin exec_cnt++; pulse_at = idx; end
    if (clr_pulse)  begin clr_cnt++;  pulse_at = idx; end
    idx++;
  endtask

  task automatic clear_counts();
    exec_cnt = 0; clr_cnt = 0; pulse_at = -1; idx = 0;
  endtask

  initial begin
    int e1_cnt, e1_at;
    segs = '{
      '{5'b00000,   40, 0, 0, -1, 3'b000},
      '{5'b00110,   40, 0, 0, -1, 3'b000},
      '{5'b10110,   40, 1, 0, 17, 3'b011},
      '{5'b00111,   40, 0, 0, -1, 3'b011},
      '{5'b00000,   40, 0, 0, -1, 3'b011},
      '{5'b11000,   40, 0, 1, 17, 3'b011},
      '{5'b00000,   40, 0, 0, -1, 3'b011},
      '{5'b10000, 1000, 1, 0, 17, 3'b000},
      '{5'b00000,   40, 0, 0, -1, 3'b000}
    };
    rst1_n = 1'b0; raw1 = '0;
    rst_n = 1'b0; raw = '0;
    clear_counts();

    // Reset with every button held, then release: clear wins over execute
    repeat (2) begin
      step(1'b0, 5'b11111);
      check("reset_outputs", int'(dut_vec()), 0);
    end
    clear_counts();
    repeat (40) step(1'b1, 5'b11111);
    check("rel_clr_count", clr_cnt, 1);
    check("rel_clr_edge", pulse_at, N + 1);
    check("rel_exec_count", exec_cnt, 0);
    check("rel_op", int'({op_btnc, op_btnl, op_btnr}), 0);

    for (int s = 0; s < 9; s++) begin
      clear_counts();
      repeat (segs[s].hold) step(1'b1, segs[s].raw);
      check("seg_exec_count", exec_cnt, segs[s].n_exec);
      check("seg_clr_count", clr_cnt, segs[s].n_clr);
      check("seg_pulse_edge", pulse_at, segs[s].pulse_at);
      check("seg_op", int'({op_btnc, op_btnl, op_btnr}), int'(segs[s].exp_op));
    end

    // Bounce: 15 high / 1 low, ten times, then stable high
    clear_counts();
    repeat (10) begin
      repeat (15) step(1'b1, 5'b10000);
      step(1'b1, 5'b00000);
    end
    check("bounce_no_exec", exec_cnt, 0);
    clear_counts();
    repeat (40) step(1'b1, 5'b10000);
    check("bounce_exec_count", exec_cnt, 1);
    check("bounce_exec_edge", pulse_at, N + 1);
    repeat (40) step(1'b1, 5'b00000);

    // Reset mid-count with button held
    clear_counts();
    repeat (12) step(1'b1, 5'b10000);
    check("midcnt_no_exec", exec_cnt, 0);
    repeat (2) step(1'b0, 5'b10000);
    idx = 0; pulse_at = -1;
    repeat (40) step(1'b1, 5'b10000);
    check("midcnt_exec_count", exec_cnt, 1);
    check("midcnt_exec_edge", pulse_at, N + 1);
    repeat (40) step(1'b1, 5'b00000);

    // DEBOUNCE_CYCLES=1 instance: strobe at edge 2 after release
    raw1 = 5'b10000;
    repeat (2) step(1'b1, 5'b00000);
    check("n1_reset_outputs",
          int'({op_btnc1, op_btnl1, op_btnr1, btnc1, btnl1, btnr1, exec1, clr1}), 0);
    rst1_n = 1'b1;
    e1_cnt = 0; e1_at = -1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 5'b00000);
      if (exec1) begin e1_cnt++; e1_at = k; end
    end
    check("n1_exec_count", e1_cnt, 1);
    check("n1_exec_edge", e1_at, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
